// File: rtl/cla16_sum_pipe.sv
`timescale 1ns/1ps
// cla16_sum_pipe: two-stage pipelined 16-bit carry-lookahead sum with valid/ready handshake.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   in_valid/in_ready  upstream handshake for the P/G word
//   P, G               per-bit propagate (A|B) and generate (A&B)
//   Pgrp, Ggrp         4-bit group propagate/generate, bit k covers bits 4k..4k+3
//   cin                carry into bit 0
//   S, cout            registered sum and carry out of bit 15
//   out_valid/out_ready downstream handshake for the result
//   xfer_cnt           wrapping count of results accepted downstream
module cla16_sum_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] P,
   input  logic [15:0] G,
   input  logic [3:0]  Pgrp,
   input  logic [3:0]  Ggrp,
   input  logic        cin,
   output logic [15:0] S,
   output logic        cout,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] xfer_cnt
);
   logic        v1, v2, adv;
   logic [15:0] p1, g1, c;
   logic [4:0]  cg, c1;
   assign adv       = ~v2 | out_ready;
   // stage 1 may refill while stage 2 stalls as long as stage 1 is empty
   assign in_ready  = ~v1 | adv;
   assign out_valid = v2;
   // group carries C0, C4, C8, C12, C16 from the lookahead inputs
   always_comb begin
      cg[0] = cin;
      for (int k = 0; k < 4; k++)
         cg[k+1] = Ggrp[k] | (Pgrp[k] & cg[k]);
   end
   // per-bit carries: each group ripples from its registered group carry
   always_comb begin
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k] = c1[k];
         for (int j = 1; j < 4; j++)
            c[4*k+j] = g1[4*k+j-1] | (p1[4*k+j-1] & c[4*k+j-1]);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         p1 <= '0;
         g1 <= '0;
         c1 <= '0;
      end else if (in_ready) begin
         v1 <= in_valid;
         p1 <= P;
         g1 <= G;
         c1 <= cg;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2   <= 1'b0;
         S    <= '0;
         cout <= 1'b0;
      end else if (adv) begin
         v2   <= v1;
         S    <= (p1 & ~g1) ^ c;
         cout <= c1[4];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) xfer_cnt <= '0;
      else if (v2 && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
   end
endmodule
